z2_cycle_tracker: RTL and testbench
===================================

Z2_CYCLE_TRACKER -- requirements
Module: z2_cycle_tracker

Interface
REQ-001 Parameter BASE_BITS, default 3: number of upper address bits compared for the Fast RAM window (ADDR[23:24-BASE_BITS]).
REQ-002 CLK  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 RESET_n  input  1  asynchronous, active-low reset.
REQ-004 AS_n  input  1  68000 address strobe, asynchronous to CLK.
REQ-005 UDS_n, LDS_n  input  1 each  data strobes, asynchronous to CLK.
REQ-006 RW  input  1  bus read/write, 1 = read.
REQ-007 ADDR  input  [23:24-BASE_BITS]  upper bus address.
REQ-008 ram_base  input  [BASE_BITS-1:0]  autoconfigured base address.
REQ-009 ram_configured  input  1  high once autoconfig has assigned ram_base.
REQ-010 ram_dtack  input  1  acknowledge pulse/level from the SDRAM controller.
REQ-011 z2_state  output  2  cycle phase: IDLE=2'b00, START=2'b01, DATA=2'b10, END=2'b11.
REQ-012 RAM_CYCLE  output  1  current cycle targets Fast RAM.
REQ-013 DTACK_n  output  1  bus acknowledge value, active low.
REQ-014 DTACK_OE  output  1  output enable for DTACK_n pad.

Function
REQ-015 AS_n and the combined strobe ds = !(UDS_n & LDS_n) SHALL each pass a 2-flop synchronizer; as_s and ds_s denote synchronized asserted levels.
REQ-016 IDLE->START only when as_s=1 and as_s was 0 on the previous clock (strobe edge); a strobe held asserted across reset release SHALL NOT start a cycle.
REQ-017 On the IDLE->START transition RAM_CYCLE SHALL latch (ram_configured && ADDR==ram_base) and hold until z2_state returns to IDLE.
REQ-018 START->DATA when ds_s=1.
REQ-019 dtack_seen SHALL set when ram_dtack=1 in any non-IDLE state with RAM_CYCLE=1, and clear only on entry to IDLE; a ram_dtack pulse of one clock SHALL suffice.
REQ-020 DATA->END when dtack_seen=1 (or ram_dtack=1 on that clock); non-RAM cycles SHALL remain in DATA.
REQ-021 Any non-IDLE state ->IDLE on the first clock with as_s=0; this SHALL take priority over every other transition.
REQ-022 DTACK_n SHALL be 0 when RAM_CYCLE=1 and dtack_seen=1 and z2_state!=IDLE, else 1.
REQ-023 DTACK_OE SHALL be 1 from START entry of a RAM cycle through exactly one clock after return to IDLE (driving DTACK_n=1 that clock), then 0.
REQ-024 A new cycle SHALL NOT start during the DTACK_OE release clock even if AS edge is detected; the edge SHALL be honoured on the following clock.
REQ-025 Outputs SHALL be registered; latency from AS_n assertion to START is 2–3 clocks.

Reset
REQ-026 While RESET_n=0: z2_state=IDLE, RAM_CYCLE=0, DTACK_n=1, DTACK_OE=0, dtack_seen=0, synchronizers=0.
REQ-027 Reset asserted mid-cycle SHALL immediately release DTACK_OE and return to IDLE without a release-drive clock.

Verification
REQ-028 ram_configured=1, ram_base=3'b010, ADDR=3'b010, read (AS/DS together), ram_dtack pulsed 1 clock -> START, DATA, END; DTACK_n=0 held until AS_n negated; DTACK_OE high one clock after IDLE.
REQ-029 Write, DS asserted 4 clocks after AS, ram_dtack pulse in START -> DTACK_n=0 while in START, state waits in START until ds_s, then DATA->END.
REQ-030 ADDR=3'b011 (mismatch) -> RAM_CYCLE=0, DTACK_OE=0 throughout, state parks in DATA until AS negated.
REQ-031 ram_configured=0 with matching address -> RAM_CYCLE=0, no DTACK drive.
REQ-032 RESET_n released with AS_n held low -> stays IDLE until AS_n negated and reasserted.
REQ-033 RESET_n pulsed low in END -> z2_state=IDLE, DTACK_OE=0, DTACK_n=1 immediately.

Source files
------------

// File: rtl/z2_cycle_tracker_if.sv
// 68000-side bus signals seen by the Zorro II cycle tracker.
// The CPU/bench drives strobes and address; the tracker answers on DTACK.
interface z2_cycle_tracker_if #(
    parameter int BASE_BITS = 3
);
    logic                   AS_n;
    logic                   UDS_n;
    logic                   LDS_n;
    logic                   RW;
    logic [23:24-BASE_BITS] ADDR;
    logic                   DTACK_n;
    logic                   DTACK_OE;

    modport master (
        output AS_n, UDS_n, LDS_n, RW, ADDR,
        input  DTACK_n, DTACK_OE
    );

    modport slave (
        input  AS_n, UDS_n, LDS_n, RW, ADDR,
        output DTACK_n, DTACK_OE
    );
endinterface

// File: rtl/z2_cycle_tracker.sv
// Follows 68000 bus cycles on the Zorro II side and generates DTACK for
// cycles that hit the autoconfigured Fast RAM window.
module z2_cycle_tracker #(
    parameter int BASE_BITS = 3
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    z2_cycle_tracker_if.slave    bus,
    input  logic [BASE_BITS-1:0] ram_base,
    input  logic                 ram_configured,
    input  logic                 ram_dtack,
    output logic [1:0]           z2_state,
    output logic                 RAM_CYCLE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_DATA  = 2'b10,
        S_END   = 2'b11
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       as_p0, as_p1;
    logic       ds_p0, ds_p1;
    logic [1:0] sync_fill;
    logic       armed;
    logic       ram_cycle, ram_next;
    logic       seen, seen_next;
    logic       dtack_n, dtack_n_next;
    logic       dtack_oe, dtack_oe_next;
    logic       ram_match;

    assign ram_match = ram_configured && (bus.ADDR == ram_base);

    // Synchronizer stages; armed records that AS was seen negated since the
    // last cycle start, so a strobe held across reset release cannot start one.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            as_p0     <= 1'b0;
            as_p1     <= 1'b0;
            ds_p0     <= 1'b0;
            ds_p1     <= 1'b0;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            as_p0     <= !bus.AS_n;
            as_p1     <= as_p0;
            ds_p0     <= !(bus.UDS_n & bus.LDS_n);
            ds_p1     <= ds_p0;
            sync_fill <= {sync_fill[0], 1'b1};
            if (state == S_IDLE && state_next == S_START)
                armed <= 1'b0;
            else if (sync_fill[1] && !as_p1)
                armed <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        ram_next   = ram_cycle;
        seen_next  = seen;
        case (state)
            S_IDLE: begin
                // dtack_oe high while idle marks the release clock
                if (as_p1 && armed && !dtack_oe) begin
                    state_next = S_START;
                    ram_next   = ram_match;
                end
            end
            S_START: if (ds_p1) state_next = S_DATA;
            S_DATA:  if (ram_cycle && (seen || ram_dtack)) state_next = S_END;
            S_END:   ;
            default: state_next = S_IDLE;
        endcase

        if (state != S_IDLE && !as_p1)
            state_next = S_IDLE;
        if (state != S_IDLE && ram_cycle && ram_dtack)
            seen_next = 1'b1;
        if (state_next == S_IDLE) begin
            ram_next  = 1'b0;
            seen_next = 1'b0;
        end

        dtack_oe_next = (state_next != S_IDLE) ? ram_next
                                               : (state != S_IDLE && ram_cycle);
        dtack_n_next  = !(ram_next && seen_next && state_next != S_IDLE);
    end

    // Output register stage
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= S_IDLE;
            ram_cycle <= 1'b0;
            seen      <= 1'b0;
            dtack_n   <= 1'b1;
            dtack_oe  <= 1'b0;
        end else begin
            state     <= state_next;
            ram_cycle <= ram_next;
            seen      <= seen_next;
            dtack_n   <= dtack_n_next;
            dtack_oe  <= dtack_oe_next;
        end
    end

    assign z2_state     = state;
    assign RAM_CYCLE    = ram_cycle;
    assign bus.DTACK_n  = dtack_n;
    assign bus.DTACK_OE = dtack_oe;

endmodule

// File: tb/tb_z2_cycle_tracker.sv
// Scoreboard bench: each scenario queues the sequence of output tuples
// {z2_state, RAM_CYCLE, DTACK_n, DTACK_OE} it must produce, in order.
module tb_z2_cycle_tracker;
    localparam int BASE_BITS = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [BASE_BITS-1:0] ram_base;
    logic                 ram_configured;
    logic                 ram_dtack;
    logic [1:0]           z2_state;
    logic                 ram_cycle;

    z2_cycle_tracker_if #(.BASE_BITS(BASE_BITS)) bus();

    z2_cycle_tracker #(.BASE_BITS(BASE_BITS)) dut (
        .CLK            (clk),
        .RESET_n        (rst_n),
        .bus            (bus),
        .ram_base       (ram_base),
        .ram_configured (ram_configured),
        .ram_dtack      (ram_dtack),
        .z2_state       (z2_state),
        .RAM_CYCLE      (ram_cycle)
    );

    always #5 clk = ~clk;

    wire [4:0] obs = {z2_state, ram_cycle, bus.DTACK_n, bus.DTACK_OE};

    logic [4:0] exp_q[$];
    string      tag_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got state=%0d ram=%0b dtack_n=%0b oe=%0b, want state=%0d ram=%0b dtack_n=%0b oe=%0b",
                     name, got[4:3], got[2], got[1], got[0], want[4:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic push(input logic [4:0] v, input string name);
        exp_q.push_back(v);
        tag_q.push_back(name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic strobes(input logic v);
        bus.AS_n  = v;
        bus.UDS_n = v;
        bus.LDS_n = v;
    endtask

    task automatic pulse_dtack();
        ram_dtack = 1'b1;
        tick(1);
        ram_dtack = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: %0d expected outputs not seen, next %s", name, exp_q.size(), tag_q[0]);
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    // Monitor: every change of the output tuple consumes one expectation.
    initial begin : monitor
        logic [4:0] prev;
        bit         first;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (first || obs !== prev) begin
                first = 1'b0;
                prev  = obs;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected output: got state=%0d ram=%0b dtack_n=%0b oe=%0b, want no change",
                             obs[4:3], obs[2], obs[1], obs[0]);
                end else begin
                    check(tag_q.pop_front(), obs, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n          = 1'b1;
        strobes(1'b1);
        bus.RW         = 1'b1;
        bus.ADDR       = 3'b010;
        ram_base       = 3'b010;
        ram_configured = 1'b1;
        ram_dtack      = 1'b0;

        push(5'b00_0_1_0, "reset state");
        #1 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        drain("reset");

        // A: RAM read, AS and DS together, one-clock dtack pulse in DATA
        push(5'b01_1_1_1, "A start");
        push(5'b10_1_1_1, "A data");
        push(5'b11_1_0_1, "A end");
        push(5'b00_0_1_1, "A release");
        push(5'b00_0_1_0, "A idle");
        strobes(1'b0);
        tick(5);
        pulse_dtack();
        tick(3);
        strobes(1'b1);
        tick(6);
        drain("A");

        // B: RAM write, DS 4 clocks late, dtack pulse while in START
        push(5'b01_1_1_1, "B start");
        push(5'b01_1_0_1, "B start dtack");
        push(5'b10_1_0_1, "B data");
        push(5'b11_1_0_1, "B end");
        push(5'b00_0_1_1, "B release");
        push(5'b00_0_1_0, "B idle");
        bus.RW   = 1'b0;
        bus.AS_n = 1'b0;
        tick(3);
        ram_dtack = 1'b1;
        tick(1);
        ram_dtack = 1'b0;
        bus.UDS_n = 1'b0;
        tick(8);
        strobes(1'b1);
        bus.RW = 1'b1;
        tick(6);
        drain("B");

        // C: address mismatch parks in DATA, no DTACK drive
        push(5'b01_0_1_0, "C start");
        push(5'b10_0_1_0, "C data");
        push(5'b00_0_1_0, "C idle");
        bus.ADDR = 3'b011;
        strobes(1'b0);
        tick(5);
        pulse_dtack();
        tick(5);
        strobes(1'b1);
        tick(6);
        drain("C");

        // D: matching address but RAM not configured
        push(5'b01_0_1_0, "D start");
        push(5'b10_0_1_0, "D data");
        push(5'b00_0_1_0, "D idle");
        bus.ADDR       = 3'b010;
        ram_configured = 1'b0;
        strobes(1'b0);
        tick(5);
        pulse_dtack();
        tick(5);
        strobes(1'b1);
        tick(6);
        ram_configured = 1'b1;
        drain("D");

        // E: AS re-edge lands on the DTACK_OE release clock
        push(5'b01_1_1_1, "E start");
        push(5'b10_1_1_1, "E data");
        push(5'b11_1_0_1, "E end");
        push(5'b00_0_1_1, "E release");
        push(5'b00_0_1_0, "E release honoured");
        push(5'b01_1_1_1, "E second start");
        push(5'b10_1_1_1, "E second data");
        push(5'b00_0_1_1, "E second release");
        push(5'b00_0_1_0, "E idle");
        strobes(1'b0);
        tick(5);
        pulse_dtack();
        tick(2);
        bus.AS_n = 1'b1;
        tick(1);
        bus.AS_n = 1'b0;
        tick(8);
        strobes(1'b1);
        tick(6);
        drain("E");

        // F: strobe held low across reset release must not start a cycle
        rst_n = 1'b0;
        strobes(1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(8);
        check("F held strobe idle", obs, 5'b00_0_1_0);
        strobes(1'b1);
        tick(4);
        push(5'b01_1_1_1, "F start");
        push(5'b10_1_1_1, "F data");
        push(5'b00_0_1_1, "F release");
        push(5'b00_0_1_0, "F idle");
        strobes(1'b0);
        tick(5);
        strobes(1'b1);
        tick(6);
        drain("F");

        // G: reset pulsed while in END
        push(5'b01_1_1_1, "G start");
        push(5'b10_1_1_1, "G data");
        push(5'b11_1_0_1, "G end");
        push(5'b00_0_1_0, "G reset");
        strobes(1'b0);
        tick(5);
        pulse_dtack();
        tick(2);
        rst_n = 1'b0;
        #1;
        check("G reset immediate", obs, 5'b00_0_1_0);
        tick(1);
        rst_n = 1'b1;
        strobes(1'b1);
        tick(6);
        drain("G");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
